display_scan_decoder: RTL and testbench

//  Monitor/decoder for the multiplexed 7-segment display bus: samples anode strobes plus the

---
 rtl/display_scan_decoder_pkg.sv | 24 ++
 rtl/seg7_to_bcd.sv | 32 +++
 rtl/display_scan_decoder.sv | 127 ++++++++++++
 tb/tb_display_scan_decoder.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/display_scan_decoder_pkg.sv
// Shared constants for the 7-segment scan decoder: active-low segment codes (a..g, a in bit 6),
// the error digit value and the frame FSM state encoding.
package display_scan_decoder_pkg;

    localparam logic [6:0] SEG_0     = 7'b0000001;
    localparam logic [6:0] SEG_1     = 7'b1001111;
    localparam logic [6:0] SEG_2     = 7'b0010010;
    localparam logic [6:0] SEG_3     = 7'b0000110;
    localparam logic [6:0] SEG_4     = 7'b1001100;
    localparam logic [6:0] SEG_5     = 7'b0100100;
    localparam logic [6:0] SEG_6     = 7'b0100000;
    localparam logic [6:0] SEG_7     = 7'b0001111;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0000100;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [3:0] DIGIT_ERR = 4'hF;

    typedef enum logic {
        StCollect,
        StComplete
    } frame_state_e;

endpackage

// File: rtl/seg7_to_bcd.sv
// Combinational decode of an active-low 7-segment pattern (a in bit 6, g in bit 0) to a BCD digit.
// Unknown patterns, including blank, give DIGIT_ERR with err set.
module seg7_to_bcd
    import display_scan_decoder_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] digit,
    output logic       err
);

    always_comb begin
        digit = DIGIT_ERR;
        err   = 1'b0;
        case (seg)
            SEG_0:   digit = 4'd0;
            SEG_1:   digit = 4'd1;
            SEG_2:   digit = 4'd2;
            SEG_3:   digit = 4'd3;
            SEG_4:   digit = 4'd4;
            SEG_5:   digit = 4'd5;
            SEG_6:   digit = 4'd6;
            SEG_7:   digit = 4'd7;
            SEG_8:   digit = 4'd8;
            SEG_9:   digit = 4'd9;
            default: begin
                digit = DIGIT_ERR;
                err   = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/display_scan_decoder.sv
// Monitor for a multiplexed 7-segment bus: captures each stable digit and emits a frame pulse once
// every position has been seen. Define DECODE_DP_EN to also track decimal points.
module display_scan_decoder
    import display_scan_decoder_pkg::*;
#(
    parameter int unsigned NUM_DIGITS    = 4,
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [NUM_DIGITS-1:0]   anodos,
    input  logic [7:0]              controles_display,
    output logic [4*NUM_DIGITS-1:0] digitos,
    output logic [NUM_DIGITS-1:0]   digito_err,
    output logic                    frame_valid,
    output logic                    error_anodo,
    output logic [NUM_DIGITS-1:0]   puntos
);

    localparam int unsigned CW = $clog2(STABLE_CYCLES + 1);
    localparam int unsigned PW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);

    logic [NUM_DIGITS-1:0] s_an_q;
    logic [7:0]            s_code_q;
    logic [PW-1:0]         prev_pos_q;
    logic [7:0]            prev_code_q;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [NUM_DIGITS-1:0] mask_q, mask_set;

    logic [PW-1:0] pos;
    int unsigned   n_low;
    logic          single, multi, match, capture;
    logic [7:0]    code_key;
    logic [3:0]    dec_digit;
    logic          dec_err;
    frame_state_e  frame_st_d;

    seg7_to_bcd u_dec (
        .seg   (s_code_q[7:1]),
        .digit (dec_digit),
        .err   (dec_err)
    );

`ifdef DECODE_DP_EN
    assign code_key = s_code_q;
`else
    // dp is masked out so it never affects stability
    assign code_key = {s_code_q[7:1], 1'b1};
    logic unused_dp;
    assign unused_dp = s_code_q[0];
`endif

    always_comb begin
        n_low = 0;
        pos   = '0;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (!s_an_q[i]) begin
                n_low = n_low + 1;
                pos   = PW'(i);
            end
        end
        single = (n_low == 1);
        multi  = (n_low > 1);

        // cnt_q != 0 only if the previous sample was a single-position sample
        match = single && (cnt_q != '0) && (prev_pos_q == pos) && (prev_code_q == code_key);
        if (!single) begin
            cnt_d = '0;
        end else if (match) begin
            cnt_d = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + 1'b1;
        end else begin
            cnt_d = CW'(1);
        end
        capture = single && (cnt_d == CNT_MAX) && !(match && (cnt_q == CNT_MAX));

        mask_set      = mask_q;
        mask_set[pos] = 1'b1;
        frame_st_d    = (capture && (&mask_set)) ? StComplete : StCollect;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            s_an_q      <= '1;
            s_code_q    <= '1;
            prev_pos_q  <= '0;
            prev_code_q <= '1;
            cnt_q       <= '0;
            mask_q      <= '0;
            digitos     <= '0;
            digito_err  <= '0;
            frame_valid <= 1'b0;
            error_anodo <= 1'b0;
        end else begin
            s_an_q      <= anodos;
            s_code_q    <= controles_display;
            prev_pos_q  <= pos;
            prev_code_q <= code_key;
            cnt_q       <= cnt_d;
            error_anodo <= multi;
            frame_valid <= 1'b0;
            if (capture) begin
                digitos[{pos, 2'b00} +: 4] <= dec_digit;
                digito_err[pos]            <= dec_err;
                if (frame_st_d == StComplete) begin
                    frame_valid <= 1'b1;
                    mask_q      <= '0;
                end else begin
                    mask_q <= mask_set;
                end
            end
        end
    end

`ifdef DECODE_DP_EN
    always_ff @(posedge CLK) begin
        if (RST) begin
            puntos <= '0;
        end else if (capture) begin
            puntos[pos] <= ~s_code_q[0];
        end
    end
`else
    assign puntos = '0;
`endif

endmodule

// File: tb/tb_display_scan_decoder.sv
// Directed bench for display_scan_decoder: vector table plus hand sequences for latency and reset.
module tb_display_scan_decoder;

    logic        CLK = 1'b0;
    logic        RST;
    logic [3:0]  anodos;
    logic [7:0]  controles_display;
    logic [15:0] digitos;
    logic [3:0]  digito_err;
    logic        frame_valid;
    logic        error_anodo;
    logic [3:0]  puntos;

    always #5 CLK = ~CLK;

    display_scan_decoder #(
        .NUM_DIGITS    (4),
        .STABLE_CYCLES (4)
    ) dut (
        .CLK               (CLK),
        .RST               (RST),
        .anodos            (anodos),
        .controles_display (controles_display),
        .digitos           (digitos),
        .digito_err        (digito_err),
        .frame_valid       (frame_valid),
        .error_anodo       (error_anodo),
        .puntos            (puntos)
    );

`ifdef DECODE_DP_EN
    localparam logic [3:0] EXP_PUNTOS_DP = 4'b0001;
`else
    localparam logic [3:0] EXP_PUNTOS_DP = 4'b0000;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    int fv_cnt = 0;
    int ea_cnt = 0;

    always @(negedge CLK) begin
        if (frame_valid === 1'b1) fv_cnt++;
        if (error_anodo === 1'b1) ea_cnt++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic hold(input logic [3:0] an, input logic [7:0] code, input int cyc);
        anodos            = an;
        controles_display = code;
        repeat (cyc) @(negedge CLK);
        #1;
    endtask

    typedef struct {
        logic [3:0]  an;
        logic [7:0]  code;
        int          cyc;
        logic [15:0] exp_dig;
        logic [3:0]  exp_err;
        int          exp_fv;
        int          exp_ea;
    } vec_t;

    vec_t vecs[13];

    initial begin
        int fv_base;
        int ea_base;

        // anodes: pos0=1110 pos1=1101 pos2=1011 pos3=0111; codes = {seg a..g, dp}
        vecs[0]  = '{4'b1110, 8'h9F, 8, 16'h0001, 4'b0000, 0, 0};  // 1 on pos0
        vecs[1]  = '{4'b1101, 8'h25, 8, 16'h0021, 4'b0000, 0, 0};  // 2 on pos1
        vecs[2]  = '{4'b1011, 8'h0D, 8, 16'h0321, 4'b0000, 0, 0};  // 3 on pos2
        vecs[3]  = '{4'b0111, 8'h99, 8, 16'h4321, 4'b0000, 1, 0};  // 4 on pos3, frame
        vecs[4]  = '{4'b1101, 8'h49, 3, 16'h4321, 4'b0000, 1, 0};  // glitch 5, too short
        vecs[5]  = '{4'b1101, 8'h41, 8, 16'h4361, 4'b0000, 1, 0};  // 6 on pos1
        vecs[6]  = '{4'b1001, 8'h41, 2, 16'h4361, 4'b0000, 1, 1};  // two anodes low
        vecs[7]  = '{4'b1011, 8'hFE, 8, 16'h4F61, 4'b0100, 1, 2};  // illegal on pos2
        vecs[8]  = '{4'b1011, 8'h1F, 8, 16'h4761, 4'b0000, 1, 2};  // 7 on pos2
        vecs[9]  = '{4'b1110, 8'h09, 8, 16'h4769, 4'b0000, 1, 2};  // 9 on pos0
        vecs[10] = '{4'b0111, 8'h01, 8, 16'h8769, 4'b0000, 2, 2};  // 8 on pos3, frame
        vecs[11] = '{4'b1111, 8'h01, 8, 16'h8769, 4'b0000, 2, 2};  // blank
        vecs[12] = '{4'b1110, 8'h03, 8, 16'h8760, 4'b0000, 2, 2};  // 0 on pos0

        // Reset with random inputs
        RST = 1'b1;
        anodos = 4'($urandom);
        controles_display = 8'($urandom);
        repeat (3) begin
            @(negedge CLK);
            anodos = 4'($urandom);
            controles_display = 8'($urandom);
        end
        #1;
        check("rst_digitos", 32'(digitos), 32'h0);
        check("rst_digito_err", 32'(digito_err), 32'h0);
        check("rst_puntos", 32'(puntos), 32'h0);
        check("rst_frame_valid", 32'(frame_valid), 32'h0);
        check("rst_error_anodo", 32'(error_anodo), 32'h0);
        check("rst_no_frame", 32'(fv_cnt), 32'h0);

        // Capture latency: output changes on the 5th edge after the input settles
        RST = 1'b0;
        hold(4'b1110, 8'h49, 4);
        check("lat_before", 32'(digitos), 32'h0);
        @(negedge CLK);
        #1;
        check("lat_after", 32'(digitos), 32'h0005);

        fv_base = fv_cnt;
        ea_base = ea_cnt;
        for (int i = 0; i < 13; i++) begin
            hold(vecs[i].an, vecs[i].code, vecs[i].cyc);
            check($sformatf("vec%0d_digitos", i), 32'(digitos), 32'(vecs[i].exp_dig));
            check($sformatf("vec%0d_err", i), 32'(digito_err), 32'(vecs[i].exp_err));
            check($sformatf("vec%0d_frames", i), 32'(fv_cnt - fv_base), 32'(vecs[i].exp_fv));
            check($sformatf("vec%0d_anode_err", i), 32'(ea_cnt - ea_base), 32'(vecs[i].exp_ea));
        end

        // Decimal point on pos0 (code 0 with dp lit)
        hold(4'b1110, 8'h02, 8);
        check("dp_digit0", 32'(digitos[3:0]), 32'h0);
        check("dp_puntos", 32'(puntos), 32'(EXP_PUNTOS_DP));

        // Mid-frame reset: pos0 captured above, capture pos1, then reset
        hold(4'b1101, 8'h9F, 8);
        check("mid_digit1", 32'(digitos), 32'h8710);
        RST = 1'b1;
        hold(4'b1111, 8'hFF, 2);
        check("mid_rst_digitos", 32'(digitos), 32'h0);
        RST = 1'b0;
        fv_base = fv_cnt;
        hold(4'b1110, 8'h1F, 8);
        hold(4'b1101, 8'h01, 8);
        hold(4'b1011, 8'h09, 8);
        check("mid_no_frame", 32'(fv_cnt - fv_base), 32'h0);
        hold(4'b0111, 8'h03, 8);
        check("mid_frame", 32'(fv_cnt - fv_base), 32'h1);
        check("mid_digitos", 32'(digitos), 32'h0987);
        check("mid_puntos", 32'(puntos), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
